s_axis_mem: RTL and testbench



---
 rtl/axis_mem_pkg.sv | 22 ++
 rtl/s_axis_mem_if.sv | 40 ++++
 rtl/s_axis_mem.sv | 181 ++++++++++++++++++
 tb/tb_s_axis_mem.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mem_pkg.sv
// -----------------------------------------------------------------------------
// axis_mem_pkg
// Shared definitions for the AXI4-Stream <-> memory block pair.
//   axis_mem_state_t : control FSM state encoding. IDLE/ACTIVE share their
//                      encoding with the stream-from-memory transmitter.
//   strb_width()     : byte-strobe width for a given data width.
// -----------------------------------------------------------------------------
package axis_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } axis_mem_state_t;

    // One strobe bit per data byte.
    function automatic int strb_width(input int data_width);
        return data_width / 32'sd8;
    endfunction

endpackage

// File: rtl/s_axis_mem_if.sv
// -----------------------------------------------------------------------------
// s_axis_mem_if
// AXI4-Stream beat channel (no TKEEP/TID/TDEST/TUSER).
//   tvalid : beat valid           (master -> slave)
//   tready : beat accept          (slave  -> master)
//   tdata  : beat data            (master -> slave)
//   tstrb  : byte strobes         (master -> slave)
//   tlast  : last beat of packet  (master -> slave)
// -----------------------------------------------------------------------------
interface s_axis_mem_if
    import axis_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [STRB_WIDTH-1:0] tstrb;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/s_axis_mem.sv
// -----------------------------------------------------------------------------
// s_axis_mem
// AXI4-Stream slave that writes one bounded burst into a synchronous memory
// write port at consecutive addresses starting from 0.
//
// Ports:
//   s_axis_aclk        clock
//   s_axis_areset      synchronous active-high reset
//   s_axis             stream slave (tvalid/tready/tdata/tstrb/tlast)
//   rx_start           arm one receive (only honoured in IDLE)
//   rx_max             last writable address, sampled on rx_start
//   rx_done            one-cycle completion pulse, coincident with final write
//   rx_count           beats written by the last receive
//   rx_overflow        packet exceeded rx_max+1 beats
//   mem_write*         registered memory write port (enable/addr/data/strb)
//
// Build option:
//   S_AXIS_MEM_DRAIN_EN  when defined, an overflowing packet is consumed to its
//                        tlast (beats discarded) before completing; otherwise
//                        the receive completes at once and tready drops,
//                        leaving the rest of the packet upstream.
// -----------------------------------------------------------------------------
module s_axis_mem
    import axis_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    s_axis_mem_if.slave           s_axis,
    input  logic                  rx_start,
    input  logic [ADDR_WIDTH-1:0] rx_max,
    output logic                  rx_done,
    output logic [ADDR_WIDTH:0]   rx_count,
    output logic                  rx_overflow,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [STRB_WIDTH-1:0] mem_write_strb
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    axis_mem_state_t       state_r;
    axis_mem_state_t       state_next_s;
    logic [ADDR_WIDTH-1:0] rx_max_r;
    logic [ADDR_WIDTH-1:0] write_pointer_r;
    logic [ADDR_WIDTH:0]   rx_count_r;
    logic                  rx_overflow_r;
    logic                  tready_r;
    logic                  rx_done_r;
    logic                  mem_write_r;
    logic [ADDR_WIDTH-1:0] mem_write_address_r;
    logic [DATA_WIDTH-1:0] mem_write_data_r;
    logic [STRB_WIDTH-1:0] mem_write_strb_r;

    logic beat_accept_s;
    logic last_addr_s;
    logic final_beat_s;
    logic overflow_beat_s;

    // tready is a register, so acceptance never depends combinationally on tvalid.
    assign beat_accept_s   = s_axis.tvalid && tready_r;
    assign last_addr_s     = (write_pointer_r == rx_max_r);
    assign final_beat_s    = s_axis.tlast || last_addr_s;
    assign overflow_beat_s = last_addr_s && !s_axis.tlast;

    // Next-state decode of the receive FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_start) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (beat_accept_s && final_beat_s) begin
                    if (overflow_beat_s) begin
`ifdef S_AXIS_MEM_DRAIN_EN
                        state_next_s = DRAIN;
`else
                        state_next_s = DONE;
`endif
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            DRAIN: begin
                if (beat_accept_s && s_axis.tlast) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus the state-decoded handshake/status outputs, registered
    // from the next state so they line up with the state they belong to.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_r   <= IDLE;
            tready_r  <= 1'b0;
            rx_done_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            tready_r  <= (state_next_s == ACTIVE) || (state_next_s == DRAIN);
            rx_done_r <= (state_next_s == DONE);
        end
    end

    // Arm on rx_start, then one-stage write register, pointer and beat counter.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            rx_max_r            <= '0;
            write_pointer_r     <= '0;
            rx_count_r          <= '0;
            rx_overflow_r       <= 1'b0;
            mem_write_r         <= 1'b0;
            mem_write_address_r <= '0;
            mem_write_data_r    <= '0;
            mem_write_strb_r    <= '0;
        end else begin
            mem_write_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_start) begin
                        rx_max_r        <= rx_max;
                        write_pointer_r <= '0;
                        rx_count_r      <= '0;
                        rx_overflow_r   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (beat_accept_s) begin
                        mem_write_r         <= 1'b1;
                        mem_write_address_r <= write_pointer_r;
                        mem_write_data_r    <= s_axis.tdata;
                        mem_write_strb_r    <= s_axis.tstrb;
                        rx_count_r          <= rx_count_r + COUNT_ONE;
                        if (overflow_beat_s) begin
                            rx_overflow_r <= 1'b1;
                        end
                        // Pointer stops at rx_max so it can never wrap.
                        if (!final_beat_s) begin
                            write_pointer_r <= write_pointer_r + PTR_ONE;
                        end
                    end
                end
                default: begin
                    // DRAIN discards beats; DONE only signals completion.
                end
            endcase
        end
    end

    assign s_axis.tready     = tready_r;
    assign rx_done           = rx_done_r;
    assign rx_count          = rx_count_r;
    assign rx_overflow       = rx_overflow_r;
    assign mem_write         = mem_write_r;
    assign mem_write_address = mem_write_address_r;
    assign mem_write_data    = mem_write_data_r;
    assign mem_write_strb    = mem_write_strb_r;

endmodule

// File: tb/tb_s_axis_mem.sv
// -----------------------------------------------------------------------------
// tb_s_axis_mem
// Directed bench for s_axis_mem (DATA_WIDTH=32, ADDR_WIDTH=5). Expected memory
// writes are queued when a beat is offered and checked when the write port
// fires. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_s_axis_mem;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start;
    logic [4:0]  rx_max;
    logic        rx_done;
    logic [5:0]  rx_count;
    logic        rx_overflow;
    logic        mem_write;
    logic [4:0]  mem_write_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_strb;

    int errors = 0;
    int checks = 0;
    wr_t sb[$];

    s_axis_mem_if #(.DATA_WIDTH(32)) s_axis ();

    s_axis_mem #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .s_axis_aclk      (clk),
        .s_axis_areset    (rst),
        .s_axis           (s_axis),
        .rx_start         (rx_start),
        .rx_max           (rx_max),
        .rx_done          (rx_done),
        .rx_count         (rx_count),
        .rx_overflow      (rx_overflow),
        .mem_write        (mem_write),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .mem_write_strb   (mem_write_strb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(mem_write_address), 64'h0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(mem_write_address), 64'(e.addr));
                check("wr_data", 64'(mem_write_data), 64'(e.data));
                check("wr_strb", 64'(mem_write_strb), 64'(e.strb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                             input logic exp_write, input logic [4:0] exp_addr);
        int n;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tstrb  = s;
        s_axis.tlast  = l;
        n = 0;
        while (s_axis.tready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("accept_timeout", 64'(s_axis.tready), 64'h1);
        end else begin
            if (exp_write) begin
                sb.push_back('{addr: exp_addr, data: d, strb: s});
            end
            @(negedge clk);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic idle_cycle();
        s_axis.tvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_rx(input logic [4:0] mx);
        rx_start = 1'b1;
        rx_max   = mx;
        @(negedge clk);
        rx_start = 1'b0;
        check("tready_armed", 64'(s_axis.tready), 64'h1);
        check("count_cleared", 64'(rx_count), 64'h0);
    endtask

    task automatic finish_checks(input string tag, input logic [5:0] cnt, input logic ovf);
        check({tag, "_done"}, 64'(rx_done), 64'h1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(rx_done), 64'h0);
        check({tag, "_tready_idle"}, 64'(s_axis.tready), 64'h0);
        check({tag, "_count"}, 64'(rx_count), 64'(cnt));
        check({tag, "_overflow"}, 64'(rx_overflow), 64'(ovf));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
    endtask

    initial begin
        rst           = 1'b1;
        rx_start      = 1'b0;
        rx_max        = 5'd0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 32'h0;
        s_axis.tstrb  = 4'h0;
        s_axis.tlast  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tready", 64'(s_axis.tready), 64'h0);
        check("rst_done", 64'(rx_done), 64'h0);
        check("rst_count", 64'(rx_count), 64'h0);
        check("rst_overflow", 64'(rx_overflow), 64'h0);
        check("rst_mem_write", 64'(mem_write), 64'h0);
        check("rst_addr", 64'(mem_write_address), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tready", 64'(s_axis.tready), 64'h0);

        // Basic: 4 beats back-to-back, tlast on 4th
        start_rx(5'd3);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h0000_00A0 + 32'(i), 4'hF, (i == 3), 1'b1, 5'(i));
        end
        check("basic_write_with_done", 64'(mem_write), 64'h1);
        finish_checks("basic", 6'd4, 1'b0);

        // Early tlast, plus rx_start ignored while in DONE
        start_rx(5'd7);
        for (int i = 0; i < 3; i++) begin
            send_beat(32'h0000_00C0 + 32'(i), 4'hF, (i == 2), 1'b1, 5'(i));
        end
        check("early_done", 64'(rx_done), 64'h1);
        check("early_tready_done", 64'(s_axis.tready), 64'h0);
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
        check("early_count", 64'(rx_count), 64'h3);
        check("early_overflow", 64'(rx_overflow), 64'h0);
        check("start_in_done_ignored", 64'(s_axis.tready), 64'h0);
        @(negedge clk);
        check("still_idle", 64'(s_axis.tready), 64'h0);
        check("early_sb_empty", 64'(sb.size()), 64'h0);

        // Gaps and strobes
        start_rx(5'd7);
        send_beat(32'h0000_00B0, 4'h1, 1'b0, 1'b1, 5'd0);
        idle_cycle();
        send_beat(32'h0000_00B1, 4'h3, 1'b0, 1'b1, 5'd1);
        idle_cycle();
        send_beat(32'h0000_00B2, 4'hF, 1'b1, 1'b1, 5'd2);
        finish_checks("gaps", 6'd3, 1'b0);

        // Overflow: rx_max=1, 4-beat packet
        start_rx(5'd1);
        send_beat(32'h0000_00D0, 4'hF, 1'b0, 1'b1, 5'd0);
        send_beat(32'h0000_00D1, 4'hF, 1'b0, 1'b1, 5'd1);
        check("ovf_flag", 64'(rx_overflow), 64'h1);
`ifdef S_AXIS_MEM_DRAIN_EN
        check("ovf_drain_no_done", 64'(rx_done), 64'h0);
        check("ovf_drain_tready", 64'(s_axis.tready), 64'h1);
        send_beat(32'h0000_00D2, 4'hF, 1'b0, 1'b0, 5'd0);
        send_beat(32'h0000_00D3, 4'hF, 1'b1, 1'b0, 5'd0);
        check("ovf_drain_no_write", 64'(mem_write), 64'h0);
        finish_checks("ovf", 6'd2, 1'b1);
`else
        check("ovf_tready_low", 64'(s_axis.tready), 64'h0);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h0000_00D2;
        s_axis.tstrb  = 4'hF;
        finish_checks("ovf", 6'd2, 1'b1);
        s_axis.tvalid = 1'b0;
`endif

        // Full size: 32 beats, no wrap
        start_rx(5'd31);
        for (int i = 0; i < 32; i++) begin
            send_beat(32'h0000_0100 + 32'(i), 4'hF, (i == 31), 1'b1, 5'(i));
        end
        finish_checks("full", 6'd32, 1'b0);

        // Reset mid-transfer
        start_rx(5'd7);
        send_beat(32'h0000_00E0, 4'hF, 1'b0, 1'b1, 5'd0);
        send_beat(32'h0000_00E1, 4'hF, 1'b0, 1'b1, 5'd1);
        rst           = 1'b1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h0000_00E2;
        @(negedge clk);
        check("rstmid_mem_write", 64'(mem_write), 64'h0);
        check("rstmid_tready", 64'(s_axis.tready), 64'h0);
        check("rstmid_count", 64'(rx_count), 64'h0);
        check("rstmid_no_done", 64'(rx_done), 64'h0);
        rst           = 1'b0;
        s_axis.tvalid = 1'b0;
        @(negedge clk);
        check("rstmid_no_done_after", 64'(rx_done), 64'h0);
        start_rx(5'd1);
        send_beat(32'h0000_00F0, 4'h5, 1'b0, 1'b1, 5'd0);
        send_beat(32'h0000_00F1, 4'hA, 1'b1, 1'b1, 5'd1);
        finish_checks("after_rst", 6'd2, 1'b0);

        repeat (2) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
